matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_loader.sv | 183 ++++++++++++++++++
 tb/tb_matrix_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - streams 25 row-major elements into a shadow buffer and presents a 5x5 matrix
// FILL gathers one frame; FULL waits for the output stage, then copies the whole shadow across in one cycle.
module matrix_loader #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic [DATA_W-1:0] in11,
   output logic [DATA_W-1:0] in12,
   output logic [DATA_W-1:0] in13,
   output logic [DATA_W-1:0] in14,
   output logic [DATA_W-1:0] in15,
   output logic [DATA_W-1:0] in21,
   output logic [DATA_W-1:0] in22,
   output logic [DATA_W-1:0] in23,
   output logic [DATA_W-1:0] in24,
   output logic [DATA_W-1:0] in25,
   output logic [DATA_W-1:0] in31,
   output logic [DATA_W-1:0] in32,
   output logic [DATA_W-1:0] in33,
   output logic [DATA_W-1:0] in34,
   output logic [DATA_W-1:0] in35,
   output logic [DATA_W-1:0] in41,
   output logic [DATA_W-1:0] in42,
   output logic [DATA_W-1:0] in43,
   output logic [DATA_W-1:0] in44,
   output logic [DATA_W-1:0] in45,
   output logic [DATA_W-1:0] in51,
   output logic [DATA_W-1:0] in52,
   output logic [DATA_W-1:0] in53,
   output logic [DATA_W-1:0] in54,
   output logic [DATA_W-1:0] in55,
   output logic              m_valid,
   input  logic              m_ack,
   output logic              frame_err,
   output logic [7:0]        mat_count
);

   localparam int          N_ELEM   = 25;
   localparam logic [4:0]  LAST_IDX = 5'd24;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [4:0]        wr_idx_q, wr_idx_d;
   logic              m_valid_q, m_valid_d;
   logic              frame_err_q, frame_err_d;
   logic [7:0]        mat_count_q, mat_count_d;
   logic [DATA_W-1:0] shadow_q [N_ELEM];
   logic [DATA_W-1:0] out_q    [N_ELEM];
   logic              accept;
   logic              do_xfer;

   assign s_ready = (state_q == FILL) && !clear && rst_n;
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      m_valid_d   = m_valid_q;
      frame_err_d = 1'b0;
      do_xfer     = 1'b0;
      if (clear) begin
         state_d   = FILL;
         wr_idx_d  = 5'd0;
         m_valid_d = 1'b0;
      end else begin
         case (state_q)
            FILL: begin
               if (accept) begin
                  if (wr_idx_q == LAST_IDX) begin
                     wr_idx_d = 5'd0;
                     if (s_last) begin
                        state_d = FULL;
                     end else begin
                        frame_err_d = 1'b1;
                     end
                  end else if (s_last) begin
                     wr_idx_d    = 5'd0;
                     frame_err_d = 1'b1;
                  end else begin
                     wr_idx_d = wr_idx_q + 5'd1;
                  end
               end
            end
            FULL: begin
               if (!m_valid_q || m_ack) begin
                  do_xfer = 1'b1;
                  state_d = FILL;
               end
            end
            default: state_d = FILL;
         endcase
         // A transfer wins over a coincident ack so the new matrix follows with no gap.
         if (do_xfer) begin
            m_valid_d = 1'b1;
         end else if (m_ack && m_valid_q) begin
            m_valid_d = 1'b0;
         end
      end
   end

   assign mat_count_d = do_xfer ? mat_count_q + 8'd1 : mat_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         wr_idx_q    <= 5'd0;
         m_valid_q   <= 1'b0;
         frame_err_q <= 1'b0;
         mat_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         m_valid_q   <= m_valid_d;
         frame_err_q <= frame_err_d;
         mat_count_q <= mat_count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ELEM; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (accept) begin
         shadow_q[wr_idx_q] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ELEM; i++) begin
            out_q[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < N_ELEM; i++) begin
            out_q[i] <= '0;
         end
      end else if (do_xfer) begin
         out_q <= shadow_q;
      end
   end

   assign m_valid   = m_valid_q;
   assign frame_err = frame_err_q;
   assign mat_count = mat_count_q;

   assign in11 = out_q[0];
   assign in12 = out_q[1];
   assign in13 = out_q[2];
   assign in14 = out_q[3];
   assign in15 = out_q[4];
   assign in21 = out_q[5];
   assign in22 = out_q[6];
   assign in23 = out_q[7];
   assign in24 = out_q[8];
   assign in25 = out_q[9];
   assign in31 = out_q[10];
   assign in32 = out_q[11];
   assign in33 = out_q[12];
   assign in34 = out_q[13];
   assign in35 = out_q[14];
   assign in41 = out_q[15];
   assign in42 = out_q[16];
   assign in43 = out_q[17];
   assign in44 = out_q[18];
   assign in45 = out_q[19];
   assign in51 = out_q[20];
   assign in52 = out_q[21];
   assign in53 = out_q[22];
   assign in54 = out_q[23];
   assign in55 = out_q[24];

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - self-checking bench for matrix_loader with a frame-level reference model
module tb_matrix_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        s_ready;
   logic        m_valid;
   logic        m_ack = 1'b0;
   logic        frame_err;
   logic [7:0]  mat_count;
   logic [31:0] got [25];

   int          checks = 0;
   int          errors = 0;
   int          fe_count = 0;
   logic [31:0] frame_buf [25];
   logic [31:0] exp_out [25];
   int          exp_count = 0;

   always #5 clk = ~clk;

   matrix_loader #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .in11(got[0]),  .in12(got[1]),  .in13(got[2]),  .in14(got[3]),  .in15(got[4]),
      .in21(got[5]),  .in22(got[6]),  .in23(got[7]),  .in24(got[8]),  .in25(got[9]),
      .in31(got[10]), .in32(got[11]), .in33(got[12]), .in34(got[13]), .in35(got[14]),
      .in41(got[15]), .in42(got[16]), .in43(got[17]), .in44(got[18]), .in45(got[19]),
      .in51(got[20]), .in52(got[21]), .in53(got[22]), .in54(got[23]), .in55(got[24]),
      .m_valid(m_valid), .m_ack(m_ack), .frame_err(frame_err), .mat_count(mat_count)
   );

   always @(negedge clk) begin
      if (rst_n && frame_err === 1'b1) fe_count++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int first_diff();
      for (int i = 0; i < 25; i++) begin
         if (got[i] !== exp_out[i]) return i;
      end
      return -1;
   endfunction

   task automatic send_elem(input logic [31:0] d, input logic last);
      bit ok = 0;
      bit rdy;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         rdy = s_ready;
         step();
         if (rdy) ok = 1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: element %0h not accepted within 200 cycles, required acceptance", d);
      end
   endtask

   task automatic send_frame(input int n, input int last_pos, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) step();
         send_elem(frame_buf[i], (i + 1) == last_pos);
      end
   endtask

   task automatic rand_frame();
      for (int i = 0; i < 25; i++) frame_buf[i] = $urandom;
   endtask

   task automatic drain();
      m_ack = 1'b1;
      step();
      m_ack = 1'b0;
   endtask

   task automatic good_frame_check(input string name, input bit gaps);
      int d;
      rand_frame();
      send_frame(25, 25, gaps);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 25; i++) exp_out[i] = frame_buf[i];
      exp_count = (exp_count + 1) % 256;
      d = first_diff();
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL %s_data: element %0d got %0h, required %0h", name, d, got[d], exp_out[d]);
      end
      checks++;
      if (m_valid !== 1'b1 || mat_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL %s_status: m_valid=%0b count=%0d, required m_valid=1 count=%0d", name, m_valid, mat_count, exp_count);
      end
      step();
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 25; i++) exp_out[i] = '0;
      checks++;
      if (first_diff() != -1 || m_valid !== 1'b0 || s_ready !== 1'b0 || mat_count !== 8'd0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: m_valid=%0b s_ready=%0b count=%0d fe=%0b in11=%0h, required all 0", m_valid, s_ready, mat_count, frame_err, got[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: s_ready=%0b, required 1", s_ready);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 25; i++) frame_buf[i] = 32'(i + 1);
      send_frame(25, 25, 0);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: m_valid=%0b s_ready=%0b one cycle after a55, required 0/0", m_valid, s_ready);
      end
      @(negedge clk);
      for (int i = 0; i < 25; i++) exp_out[i] = frame_buf[i];
      exp_count = 1;
      checks++;
      if (got[0] !== 32'd1 || got[4] !== 32'd5 || got[24] !== 32'd25 || first_diff() != -1) begin
         errors++;
         $display("FAIL basic_data: in11=%0d in15=%0d in55=%0d, required 1/5/25", got[0], got[4], got[24]);
      end
      checks++;
      if (m_valid !== 1'b1 || mat_count !== 8'd1) begin
         errors++;
         $display("FAIL basic_status: m_valid=%0b count=%0d, required 1/1", m_valid, mat_count);
      end
      step();
   endtask

   task automatic test_backpressure();
      int d;
      for (int i = 0; i < 25; i++) frame_buf[i] = 32'(101 + i);
      send_frame(25, 25, 0);
      repeat (3) @(negedge clk);
      d = first_diff();
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || d != -1) begin
         errors++;
         $display("FAIL bp_hold: s_ready=%0b m_valid=%0b diff_idx=%0d, required 0/1/-1", s_ready, m_valid, d);
      end
      step();
      m_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_ack_cycle: m_valid=%0b, required 1", m_valid);
      end
      step();
      m_ack = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 25; i++) exp_out[i] = frame_buf[i];
      exp_count = 2;
      d = first_diff();
      checks++;
      if (d != -1 || m_valid !== 1'b1 || mat_count !== 8'd2) begin
         errors++;
         $display("FAIL bp_swap: diff_idx=%0d m_valid=%0b count=%0d, required -1/1/2", d, m_valid, mat_count);
      end
      step();
      drain();
      @(negedge clk);
      d = first_diff();
      checks++;
      if (m_valid !== 1'b0 || d != -1) begin
         errors++;
         $display("FAIL ack_clears: m_valid=%0b diff_idx=%0d, required 0/-1", m_valid, d);
      end
      step();
   endtask

   task automatic test_short_frame();
      int fe0 = fe_count;
      rand_frame();
      send_frame(10, 10, 0);
      repeat (2) @(negedge clk);
      checks++;
      if (fe_count - fe0 != 1 || m_valid !== 1'b0 || mat_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL short_frame: fe_pulses=%0d m_valid=%0b count=%0d, required 1/0/%0d", fe_count - fe0, m_valid, mat_count, exp_count);
      end
      step();
      good_frame_check("short_recover", 0);
      drain();
   endtask

   task automatic test_long_frame();
      int fe0 = fe_count;
      rand_frame();
      send_frame(25, 0, 0);
      repeat (2) @(negedge clk);
      checks++;
      if (fe_count - fe0 != 1 || m_valid !== 1'b0 || mat_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL long_frame: fe_pulses=%0d m_valid=%0b count=%0d, required 1/0/%0d", fe_count - fe0, m_valid, mat_count, exp_count);
      end
      step();
      good_frame_check("long_recover", 0);
   endtask

   task automatic test_clear();
      rand_frame();
      send_frame(12, 0, 0);
      clear   = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL clear_ready: s_ready=%0b, required 0", s_ready);
      end
      step();
      clear   = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 25; i++) exp_out[i] = '0;
      checks++;
      if (first_diff() != -1 || m_valid !== 1'b0 || frame_err !== 1'b0 || mat_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL clear_state: in11=%0h m_valid=%0b fe=%0b count=%0d, required 0/0/0/%0d", got[0], m_valid, frame_err, mat_count, exp_count);
      end
      step();
      good_frame_check("clear_recover", 1);
   endtask

   task automatic test_async_reset();
      rand_frame();
      send_frame(7, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 25; i++) exp_out[i] = '0;
      exp_count = 0;
      checks++;
      if (first_diff() != -1 || m_valid !== 1'b0 || mat_count !== 8'd0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: in11=%0h m_valid=%0b count=%0d s_ready=%0b, required all 0", got[0], m_valid, mat_count, s_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      good_frame_check("reset_recover", 0);
   endtask

   task automatic test_random_frames();
      drain();
      for (int f = 0; f < 12; f++) begin
         int kind = $urandom_range(0, 2);
         int fe0 = fe_count;
         if (kind == 0) begin
            good_frame_check("rand_good", 1);
            checks++;
            if (fe_count != fe0) begin
               errors++;
               $display("FAIL rand_good_fe: pulses=%0d, required 0", fe_count - fe0);
            end
         end else begin
            int n = (kind == 1) ? $urandom_range(1, 24) : 25;
            int d;
            rand_frame();
            send_frame(n, (kind == 1) ? n : 0, 1);
            repeat (2) @(negedge clk);
            d = first_diff();
            checks++;
            if (fe_count - fe0 != 1 || m_valid !== 1'b0 || d != -1 || mat_count !== 8'(exp_count)) begin
               errors++;
               $display("FAIL rand_bad: kind=%0d len=%0d fe=%0d m_valid=%0b diff=%0d count=%0d, required 1/0/-1/%0d", kind, n, fe_count - fe0, m_valid, d, mat_count, exp_count);
            end
            step();
         end
         drain();
      end
   endtask

   task automatic test_wrap();
      m_ack = 1'b1;
      for (int f = 0; f < 256; f++) begin
         rand_frame();
         send_frame(25, 25, 0);
         repeat (2) @(negedge clk);
         exp_count = (exp_count + 1) % 256;
         for (int i = 0; i < 25; i++) exp_out[i] = frame_buf[i];
         if (exp_count == 255 || exp_count == 0) begin
            checks++;
            if (mat_count !== 8'(exp_count) || first_diff() != -1) begin
               errors++;
               $display("FAIL wrap_count: count=%0d diff_idx=%0d, required %0d/-1", mat_count, first_diff(), exp_count);
            end
         end
         step();
      end
      m_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_short_frame();
      test_long_frame();
      test_clear();
      test_async_reset();
      test_random_frames();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
